pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage RV32I pipeline. Drives the enable/flush
//  controls of PC, IF/ID, ID/EX, EX/MEM and the MEM/WB register. Resolves load-use hazards,
//  taken-branch flushes and multi-cycle data-memory waits, with a memory-timeout error trap.
//  Also keeps saturating stall and flush counters for performance monitoring.
// PARAMETERS
//  MEM_TIMEOUT  16  consecutive dmem not-ready cycles before entering ERROR (>=2)
//  CNT_W        32  width of stall_cnt / flush_cnt
// PORTS
//  clk            in   1      clock; all state updates on posedge
//  reset          in   1      synchronous, active-low reset (sampled on posedge clk)
//  id_rs1         in   5      rs1 of instruction in ID
//  id_rs2         in   5      rs2 of instruction in ID
//  id_use_rs1     in   1      ID instruction reads rs1
//  id_use_rs2     in   1      ID instruction reads rs2
//  ex_is_load     in   1      instruction in EX is a load
//  ex_rd          in   5      destination of instruction in EX
//  ex_br_taken    in   1      EX resolved a taken branch/jump (redirect)
//  mem_req        in   1      instruction in MEM accesses data memory
//  dmem_ready     in   1      data memory completes access this cycle
//  pc_en          out  1      PC update enable
//  if_id_en       out  1      IF/ID load enable
//  if_id_flush    out  1      IF/ID load bubble
//  id_ex_en       out  1      ID/EX load enable
//  id_ex_flush    out  1      ID/EX load bubble
//  ex_mem_en      out  1      EX/MEM load enable
//  mem_wb_bubble  out  1      force reg_wr=0, wb_sel=0 into MEM/WB this cycle
//  bus_err        out  1      sticky memory-timeout error
//  stall_cnt      out  CNT_W  saturating count of cycles with pc_en=0 (RUN/MEM_WAIT only)
//  flush_cnt      out  CNT_W  saturating count of taken-branch flushes
// BEHAVIOUR
//  States: RUN, MEM_WAIT, ERROR. Reset (reset==0 at posedge): state=RUN, wait_cnt=0,
//   bus_err=0, stall_cnt=0, flush_cnt=0. While reset==0, all *_en=0, flushes=0, bubble=0.
//  Outputs are combinational from state + inputs; counters/state/bus_err registered.
//  freeze = (RUN & mem_req & !dmem_ready) | (MEM_WAIT & !dmem_ready) | ERROR.
//  freeze=1: pc_en=if_id_en=id_ex_en=ex_mem_en=0, flushes=0, mem_wb_bubble=1.
//  freeze=0, priority 1 ex_br_taken: pc_en=1, all en=1, if_id_flush=id_ex_flush=1;
//   flush_cnt++ (sat). Load-use ignored (younger instruction is discarded).
//  freeze=0, priority 2 load-use = ex_is_load & ex_rd!=0 &
//   ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)):
//   pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, ex_mem_en=1 -> exactly 1 bubble.
//  freeze=0, otherwise: all en=1, no flush, mem_wb_bubble=0.
//  Branch/load-use arriving during freeze are held by frozen stages; act on first unfrozen cycle.
//  RUN: mem_req & !dmem_ready -> MEM_WAIT, wait_cnt=1. mem_req & dmem_ready -> stay, no stall.
//  MEM_WAIT: dmem_ready -> RUN (that cycle unfrozen), wait_cnt=0;
//   else if wait_cnt==MEM_TIMEOUT-1 -> ERROR, bus_err=1; else wait_cnt++.
//   => ERROR entered at edge ending the MEM_TIMEOUT-th consecutive not-ready cycle.
//  ERROR: permanent freeze, bus_err=1, counters hold; left only via reset.
//  stall_cnt++ each cycle pc_en=0 in RUN/MEM_WAIT; both counters saturate at all-ones.
//  Reset mid-MEM_WAIT: next cycle RUN, counters 0, no residual stall.
// TESTING
//  1 load x5 in EX, ID reads rs2=x5 -> 1 cycle pc_en=0,if_id_en=0,id_ex_flush=1; stall_cnt=1.
//  2 load x0 in EX, ID reads x0 -> no stall; ex_br_taken + load-use same cycle -> flush only,
//    pc_en=1, flush_cnt=1, stall_cnt=0.
//  3 mem_req, dmem_ready low 3 cycles then high -> 3 frozen cycles with mem_wb_bubble=1,
//    4th cycle unfrozen, state RUN, stall_cnt=3.
//  4 MEM_TIMEOUT=4, mem_req held, dmem_ready=0 -> bus_err=1 after 4th not-ready cycle,
//    all enables 0 forever; reset low 1 cycle -> RUN, bus_err=0, counters 0.
//  5 ex_br_taken during MEM_WAIT -> no flush until dmem_ready; flush on that cycle.
//  6 CNT_W=4, 20 load-use stalls -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use bubbles, branch flushes,
// data-memory wait freeze with timeout trap, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_bubble,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic            bus_err_nxt;
    logic            freeze;
    logic            load_use;
    logic            stall_inc;
    logic            flush_inc;

    always_comb begin
        freeze = ((state == RUN) && mem_req && !dmem_ready)
              || ((state == MEM_WAIT) && !dmem_ready)
              || (state == ERROR);
        load_use = ex_is_load && (ex_rd != 5'd0)
                && ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    // Outputs are forced quiet while reset is held, regardless of state.
    always_comb begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b0;
        if (reset) begin
            if (freeze) begin
                mem_wb_bubble = 1'b1;
            end else if (ex_br_taken) begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_en    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_en   = 1'b1;
            end else if (load_use) begin
                id_ex_en    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_en   = 1'b1;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        bus_err_nxt  = bus_err;
        case (state)
            RUN: begin
                if (mem_req && !dmem_ready) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WC_LAST) begin
                    state_nxt   = ERROR;
                    bus_err_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            ERROR: begin
                bus_err_nxt = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // ERROR freezes everything but is not counted as stall time.
    always_comb begin
        stall_inc = !pc_en && (state != ERROR);
        flush_inc = !freeze && ex_br_taken;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            bus_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            bus_err  <= bus_err_nxt;
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
